// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, keeps one imem request in flight and buffers {pc, instr} in a FIFO for decode.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect sets sticky fetch_misaligned and halts fetching.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
`ifdef FETCH_MISALIGN_CHECK_EN
        DRAIN,
        HALT
`else
        DRAIN
`endif
    } state_t;

    state_t state, state_next, settle;
    logic [31:0] fetch_pc, req_pc, target;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0] fifo_pc [FIFO_DEPTH];
    logic [31:0] fifo_instr [FIFO_DEPTH];
    logic hs, push, pop;

    // Space is judged from the registered count only, so out_ready never reaches imem_req_valid.
    assign imem_req_valid = rst && state == FETCH && !redirect_valid && count < CW'(FIFO_DEPTH);
    assign imem_req_addr = fetch_pc;
    assign hs = imem_req_valid && imem_req_ready;
    assign push = state == WAIT && imem_resp_valid && !redirect_valid;
    assign out_valid = rst && count != '0;
    assign pop = out_valid && out_ready;
    assign instruction = out_valid ? fifo_instr[rd_ptr] : '0;
    assign pc = out_valid ? fifo_pc[rd_ptr] : '0;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_next;
    assign target = redirect_pc;
    assign mis_next = fetch_misaligned | (redirect_valid & |redirect_pc[1:0]);
    assign settle = mis_next ? HALT : FETCH;
    always_ff @(posedge clk)
        fetch_misaligned <= !rst ? 1'b0 : mis_next;
`else
    assign target = redirect_pc & ~32'd3;
    assign settle = FETCH;
`endif

    // A response seen in the redirect cycle is the one being flushed, so WAIT need not drain.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: state_next = redirect_valid ? (hs ? DRAIN : settle) : (hs ? WAIT : FETCH);
            WAIT: state_next = imem_resp_valid ? settle : (redirect_valid ? DRAIN : WAIT);
            DRAIN: state_next = imem_resp_valid ? settle : DRAIN;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
            fetch_pc <= RESET_PC;
            req_pc <= '0;
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                fetch_pc <= target;
                count <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (hs) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    req_pc <= fetch_pc;
                end
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr] <= req_pc;
            fifo_instr[wr_ptr] <= imem_resp_data;
        end
    end
endmodule
